// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : store-kind codes and the store-entry layout for the M-stage path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [2:0] BE_SW  = 3'd0;
  localparam logic [2:0] BE_SH  = 3'd1;
  localparam logic [2:0] BE_SB  = 3'd2;
  localparam logic [2:0] BE_SWL = 3'd3;
  localparam logic [2:0] BE_SWR = 3'd4;

  localparam int STORE_AW = 32;

  typedef struct packed {
    logic [STORE_AW-1:0] addr;
    logic [3:0]          be;
    logic [31:0]         data;
  } store_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_align.sv
// ---------------------------------------------------------------------------
// store_align : byte-enable and lane-aligned data for one store
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_align
  import mips_pkg::*;
(
  input  logic [2:0]  be_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt,
  output logic [3:0]  be,
  output logic [31:0] data
);

  always_comb begin
    be   = 4'b1111;
    data = rt;
    case (be_ctrl)
      BE_SH: begin
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        data = {2{rt[15:0]}};
      end
      BE_SB: begin
        be   = 4'b0001 << addr_lo;
        data = {4{rt[7:0]}};
      end
      // Unaligned-word halves: swl fills from the low lanes up, swr from the high lanes down.
      BE_SWL: begin
        case (addr_lo)
          2'd0: begin be = 4'b0001; data = rt >> 24; end
          2'd1: begin be = 4'b0011; data = rt >> 16; end
          2'd2: begin be = 4'b0111; data = rt >> 8;  end
          2'd3: begin be = 4'b1111; data = rt;       end
        endcase
      end
      BE_SWR: begin
        case (addr_lo)
          2'd0: begin be = 4'b1111; data = rt;       end
          2'd1: begin be = 4'b1110; data = rt << 8;  end
          2'd2: begin be = 4'b1100; data = rt << 16; end
          2'd3: begin be = 4'b1000; data = rt << 24; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_store_buffer.sv
// ---------------------------------------------------------------------------
// dm_store_buffer : M-stage store FIFO draining to the data-memory bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dm_we,
  input  logic [2:0]    be_ctrl,
  input  logic          ld,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  entry_t        head_q, head_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] remain;

  logic [3:0]    al_be;
  logic [31:0]   al_data;
  entry_t        new_entry;
  logic          full, push, pop;

  store_align u_align (
    .be_ctrl (be_ctrl),
    .addr_lo (addr[1:0]),
    .rt      (wdata),
    .be      (al_be),
    .data    (al_data)
  );

  always_comb begin
    new_entry.addr = {addr[AW-1:2], 2'b00};
    new_entry.be   = al_be;
    new_entry.data = al_data;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign mem_req = ~empty;
  assign pop     = mem_req & mem_ack;
  assign stall   = (dm_we & full & ~pop) | (ld & ~empty);
  assign push    = dm_we & ~stall;

  assign mem_addr  = head_q.addr;
  assign mem_be    = head_q.be;
  assign mem_wdata = head_q.data;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (push) begin
      fifo_d[wr_ptr_q] = new_entry;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    remain  = count_q - {{(CW-1){1'b0}}, pop};
    count_d = remain + {{(CW-1){1'b0}}, push};
    // Output register tracks the post-edge head; a store into a draining-empty FIFO bypasses storage.
    if (count_d != '0) begin
      head_d = (remain == '0) ? new_entry : fifo_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q   <= '{default: '0};
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fifo_q   <= fifo_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire
